// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [7:0]  START_BYTE             = 8'hA5;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

    // States in which a load is in flight and the inter-byte timer runs.
    function automatic logic load_active(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four little-endian bytes into a 32-bit word and flags the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_full,
    output logic [31:0] word_data
);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;

    // Bytes enter at the top and shift down, so the first byte lands in [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (clr) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

    assign word_full = byte_valid && (idx_q == 2'd3);
    assign word_data = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: framed byte stream -> instruction memory writes, CPU held in reset.
//
// state  | meaning
// IDLE   | waiting for start byte, CPU running
// LEN_LO | expecting word count low byte
// LEN_HI | expecting word count high byte, length checked
// DATA   | receiving instruction bytes, one write per 4 bytes
// CHECK  | expecting XOR checksum byte
// DONE   | load good, CPU released
// ERR    | load aborted, CPU held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W         = 14,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    localparam int          TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       len_full;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [7:0]        csum_q;
    logic [TW-1:0]     tmo_q;
    logic              start_hit, tmo_hit, last_word, run_d;
    logic              pk_valid, pk_full;
    logic [31:0]       pk_word;

    assign start_hit = rx_valid && (rx_data == START_BYTE) &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign tmo_hit   = load_active(state_q) && (tmo_q == TMO_LAST);
    assign len_full  = {rx_data, len_q[7:0]};
    assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);
    assign pk_valid  = rx_valid && (state_q == DATA);

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_hit),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word_full  (pk_full),
        .word_data  (pk_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An accepted byte always takes priority over an expiring timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_hit) state_d = LEN_LO;
            LEN_LO: begin
                if (rx_valid)     state_d = LEN_HI;
                else if (tmo_hit) state_d = ERR;
            end
            LEN_HI: begin
                if (rx_valid) begin
                    if (32'(len_full) > MAX_WORDS) state_d = ERR;
                    else if (len_full == 16'd0)    state_d = CHECK;
                    else                           state_d = DATA;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (pk_full && last_word) state_d = CHECK;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            CHECK: begin
                if (rx_valid)     state_d = (rx_data == csum_q) ? DONE : ERR;
                else if (tmo_hit) state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done  = (state_q == DONE);
        err   = (state_q == ERR);
        run_d = (state_q == IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
        end else begin
            imem_we   <= 1'b0;
            cpu_rst_n <= run_d;
            if (start_hit) begin
                len_q      <= '0;
                word_cnt_q <= '0;
                csum_q     <= '0;
            end
            if ((state_q == LEN_LO) && rx_valid) len_q[7:0]  <= rx_data;
            if ((state_q == LEN_HI) && rx_valid) len_q[15:8] <= rx_data;
            if (pk_valid) begin
                csum_q <= csum_q ^ rx_data;
                if (pk_full) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_cnt_q;
                    imem_wdata <= pk_word;
                    word_cnt_q <= word_cnt_q + ADDR_W'(1);
                end
            end
            if (!load_active(state_q) || rx_valid) tmo_q <= '0;
            else if (!tmo_hit)                      tmo_q <= tmo_q + TW'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int ADDR_W = 14;
    localparam int TMO    = 16;

    typedef logic [7:0]  bq_t[$];
    typedef logic [45:0] wq_t[$];

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;

    int  n_cmp  = 0;
    int  n_fail = 0;
    wq_t got;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .err        (err)
    );

    always @(negedge clk) if (imem_we === 1'b1) got.push_back({imem_addr, imem_wdata});

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: length rule, little-endian words, XOR checksum, silence means timeout.
    function automatic void model(input bq_t s, output wq_t w, output logic d, output logic e);
        int n, p;
        logic [7:0] cs;
        w = {}; d = 1'b0; e = 1'b0;
        if (s.size() < 3) begin e = 1'b1; return; end
        n = int'(s[1]) + 256 * int'(s[2]);
        if (n > (1 << ADDR_W)) begin e = 1'b1; return; end
        cs = 8'h00;
        p  = 3;
        for (int k = 0; k < n; k++) begin
            if (p + 4 > s.size()) begin e = 1'b1; return; end
            w.push_back({14'(k), s[p+3], s[p+2], s[p+1], s[p]});
            cs = cs ^ s[p] ^ s[p+1] ^ s[p+2] ^ s[p+3];
            p  = p + 4;
        end
        if (p >= s.size()) begin e = 1'b1; return; end
        if (s[p] == cs) d = 1'b1;
        else            e = 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_stream(input string tag, input bq_t s, input int gap_max);
        wq_t  w;
        logic d, e;
        model(s, w, d, e);
        got.delete();
        foreach (s[i]) send_byte(s[i], int'($urandom_range(gap_max, 0)));
        repeat (20) @(negedge clk);
        check({tag, " n_writes"}, 64'(got.size()), 64'(w.size()));
        foreach (w[i])
            check($sformatf("%s write%0d", tag, i),
                  (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(w[i]));
        check({tag, " done"}, 64'(done), 64'(d));
        check({tag, " err"}, 64'(err), 64'(e));
        check({tag, " cpu_rst_n"}, 64'(cpu_rst_n), 64'(d));
    endtask

    initial begin
        bq_t        s;
        logic [7:0] cs;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst imem_we", 64'(imem_we), 64'd0);
        check("rst imem_addr", 64'(imem_addr), 64'd0);
        check("rst imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst cpu_rst_n", 64'(cpu_rst_n), 64'd1);

        // Data-byte XOR of this frame is 0x90.
        s = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        run_stream("good", s, 2);
        check("good word0", (got.size() > 0) ? 64'(got[0]) : 64'hx, 64'({14'd0, 32'h0000_0013}));
        check("good word1", (got.size() > 1) ? 64'(got[1]) : 64'hx, 64'({14'd1, 32'h0010_0093}));

        got.delete();
        send_byte(8'hA5, 0);
        check("restart-done done", 64'(done), 64'd0);
        check("restart-done err", 64'(err), 64'd0);
        @(negedge clk);
        check("restart-done cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        cs = 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
        s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, cs};
        foreach (s[i]) send_byte(s[i], 1);
        repeat (4) @(negedge clk);
        check("restart n_writes", 64'(got.size()), 64'd1);
        check("restart word0", (got.size() > 0) ? 64'(got[0]) : 64'hx, 64'({14'd0, 32'hDEAD_BEEF}));
        check("restart done", 64'(done), 64'd1);

        s = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        run_stream("badsum", s, 1);

        s = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_stream("zero-ok", s, 0);
        s = {8'hA5, 8'h00, 8'h00, 8'h01};
        run_stream("zero-bad", s, 0);

        s = {8'hA5, 8'h01, 8'h40};
        run_stream("oversize", s, 0);

        got.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        check("max-len no err", 64'(err), 64'd0);
        repeat (20) @(negedge clk);
        check("max-len timeout err", 64'(err), 64'd1);
        check("max-len n_writes", 64'(got.size()), 64'd0);

        got.delete();
        send_byte(8'hA5, 0);
        check("restart-err err", 64'(err), 64'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        repeat (15) @(negedge clk);
        check("timeout before expiry", 64'(err), 64'd0);
        @(negedge clk);
        check("timeout at expiry", 64'(err), 64'd1);
        check("timeout cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("timeout n_writes", 64'(got.size()), 64'd0);

        got.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        repeat (15) @(negedge clk);
        send_byte(8'h22, 0);
        check("byte-on-expiry err", 64'(err), 64'd0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0);
        repeat (4) @(negedge clk);
        check("byte-on-expiry done", 64'(done), 64'd1);
        check("byte-on-expiry word0", (got.size() > 0) ? 64'(got[0]) : 64'hx,
              64'({14'd0, 32'h4433_2211}));

        for (int it = 0; it < 8; it++) begin
            int         n;
            logic [7:0] b;
            n  = int'($urandom_range(5, 0));
            s  = {8'hA5, 8'(n), 8'h00};
            cs = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                b = 8'($urandom);
                s.push_back(b);
                cs = cs ^ b;
            end
            if ($urandom_range(2, 0) == 0) cs = cs ^ 8'(1 + $urandom_range(254, 0));
            s.push_back(cs);
            run_stream($sformatf("rand%0d", it), s, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
